// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data_memory between the core
// load/store path and the loader/debug port.
// Access sequence per transaction: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
// The core has fixed priority. Define ARB_STARVE_GUARD_EN to enable the loader
// starvation guard, which forces a loader grant after STARVE_LIMIT lost
// arbitrations.
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,

    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_ack_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,

    input  logic                  ldr_req_i,
    input  logic                  ldr_we_i,
    input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
    input  logic [DATA_WIDTH-1:0] ldr_wdata_i,
    output logic                  ldr_ack_o,
    output logic [DATA_WIDTH-1:0] ldr_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output logic                  mem_wr_enable_o,
    output logic                  mem_rd_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,

    output logic                  busy_o
);

    // Reject starvation limits the 8-bit wait counter cannot represent.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("data_mem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;        // 1 = loader owns the access
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wr_data_d;
    logic                    mem_wr_enable_d;
    logic                    mem_rd_enable_d;
    logic                    core_ack_d;
    logic                    ldr_ack_d;
    logic                    busy_d;
    logic                    starve_c;
    logic                    ldr_win_c;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned  CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

    assign starve_c = (wait_cnt_q == LIMIT);

    // Count loader arbitration losses in IDLE; saturate, clear on loader grant.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_IDLE) begin
            if (ldr_win_c) begin
                wait_cnt_d = '0;
            end else if (ldr_req_i && core_req_i && (wait_cnt_q != LIMIT)) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign starve_c = 1'b0;
`endif

    // Loader wins when the core is idle or the starvation guard forces it.
    assign ldr_win_c = ldr_req_i && (!core_req_i || starve_c);

    // Next state, grant and registered memory/response outputs.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rdata_d         = rdata_q;
        mem_addr_d      = mem_addr_o;
        mem_wr_data_d   = mem_wr_data_o;
        mem_wr_enable_d = 1'b0;
        mem_rd_enable_d = 1'b0;
        core_ack_d      = 1'b0;
        ldr_ack_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (core_req_i || ldr_req_i) begin
                    state_d = S_ACCESS;
                    grant_d = ldr_win_c;
                    if (ldr_win_c) begin
                        mem_addr_d      = ldr_addr_i;
                        mem_wr_data_d   = ldr_wdata_i;
                        mem_wr_enable_d = ldr_we_i;
                        mem_rd_enable_d = !ldr_we_i;
                    end else begin
                        mem_addr_d      = core_addr_i;
                        mem_wr_data_d   = core_wdata_i;
                        mem_wr_enable_d = core_we_i;
                        mem_rd_enable_d = !core_we_i;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Memory read data is valid this cycle; ack lands with DONE.
                state_d    = S_DONE;
                rdata_d    = mem_rd_data_i;
                core_ack_d = !grant_q;
                ldr_ack_d  = grant_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q         <= S_IDLE;
            grant_q         <= 1'b0;
            rdata_q         <= '0;
            mem_addr_o      <= '0;
            mem_wr_data_o   <= '0;
            mem_wr_enable_o <= 1'b0;
            mem_rd_enable_o <= 1'b0;
            core_ack_o      <= 1'b0;
            ldr_ack_o       <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rdata_q         <= rdata_d;
            mem_addr_o      <= mem_addr_d;
            mem_wr_data_o   <= mem_wr_data_d;
            mem_wr_enable_o <= mem_wr_enable_d;
            mem_rd_enable_o <= mem_rd_enable_d;
            core_ack_o      <= core_ack_d;
            ldr_ack_o       <= ldr_ack_d;
            busy_o          <= busy_d;
        end
    end

    // Both ports see the shared read-data register.
    assign core_rdata_o = rdata_q;
    assign ldr_rdata_o  = rdata_q;

endmodule
